// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline.
//   INSTR_W / ADDR_W   : instruction and byte-address widths
//   NOP                : all-zero word (sll $0,$0,0), used to flush pipeline registers
//   DEFAULT_RESET_PC   : default PC after reset
//   if_id_t            : payload carried by the IF/ID pipeline register
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// One-entry IF/ID pipeline register.
//   clk, rst_n : clock, asynchronous active-low clear (payload -> zeros, valid -> 0)
//   load       : capture d and mark valid
//   flush      : drop the entry; instr becomes NOP, pc fields keep their value
//   d          : incoming payload
//   valid, q   : registered valid flag and payload
// flush has priority over load.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);

  logic   valid_q;
  if_id_t data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      data_q.instr <= NOP;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and captures the returned word into the IF/ID register.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_addr / imem_instr      : byte address out (= pc), instruction word back
//   redirect_valid, redirect_pc : taken branch/jump; flushes the IF/ID entry
//   id_ready                    : decode accepts if_* this cycle
//   if_valid, if_instr, if_pc,
//   if_pc_plus4                 : IF/ID register outputs
//   fetch_fault                 : sticky flag for a misaligned redirect target
// RESET_PC must be word aligned and below IMEM_WORDS*4.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned       IMEM_WORDS = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic               fetch_fault
);

  localparam logic [ADDR_W-1:0] ImemBytes = ADDR_W'(IMEM_WORDS * 4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4, next_seq;
  logic              fault_q, fault_d;
  logic              advance, load, flush;
  logic              valid;
  if_id_t            entry_d, entry_q;

  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + ADDR_W'(4);
  // Sequential fetch wraps at the end of instruction memory; if_pc_plus4 does not.
  assign next_seq  = (pc_plus4 == ImemBytes) ? '0 : pc_plus4;
  assign advance   = !fault_q && (!valid || id_ready);

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    load    = 1'b0;
    flush   = 1'b0;
    // Once faulted, fetch is frozen and redirects are ignored until reset.
    if (redirect_valid && !fault_q) begin
      flush = 1'b1;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d = redirect_pc;
      end else begin
        fault_d = 1'b1;
      end
    end else if (advance) begin
      load = 1'b1;
      pc_d = next_seq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign entry_d = '{instr: imem_instr, pc: pc_q, pc_plus4: pc_plus4};

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .flush (flush),
    .d     (entry_d),
    .valid (valid),
    .q     (entry_q)
  );

  assign if_valid    = valid;
  assign if_instr    = entry_q.instr;
  assign if_pc       = entry_q.pc;
  assign if_pc_plus4 = entry_q.pc_plus4;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_fault;

  logic [31:0] imem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem[imem_addr[9:2]];

  fetch_stage #(
    .RESET_PC   (32'h0),
    .IMEM_WORDS (256)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fetch_fault    (fetch_fault)
  );

  // Next sequential byte address in a 1 KiB instruction memory.
  function automatic logic [31:0] seq_next(input logic [31:0] a);
    logic [31:0] n;
    n = (a + 32'd4) % 32'd1024;
    return n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", if_pc); end
    checks++; if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h want 0", if_pc_plus4); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fetch_fault); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_sequence();
    logic [31:0] seq [4];
    seq[0] = 32'h8C09_0000; seq[1] = 32'h8C0A_0004;
    seq[2] = 32'h012A_5820; seq[3] = 32'hAC0B_0008;
    for (int k = 0; k < 4; k++) imem[k] = seq[k];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b want 1", k, if_valid); end
      checks++; if (if_instr !== seq[k]) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", k, if_instr, seq[k]); end
      checks++; if (if_pc !== 32'(k * 4)) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", k, if_pc, k * 4); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", k, if_valid); end
      checks++; if (if_instr !== 32'h8C0A_0004) begin errors++; $display("FAIL bp_instr[%0d] got %h want 8c0a0004", k, if_instr); end
      checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL bp_pc[%0d] got %h want 4", k, if_pc); end
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr[%0d] got %h want 8", k, imem_addr); end
    end
    id_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_instr !== 32'h012A_5820) begin errors++; $display("FAIL bp_resume got %h want 012a5820", if_instr); end
    checks++; if (if_pc !== 32'h8) begin errors++; $display("FAIL bp_resume_pc got %h want 8", if_pc); end
  endtask

  task automatic test_redirect_flush();
    imem[16] = 32'h2408_1234;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    id_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rd_instr got %h want 0", if_instr); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL rd_addr got %h want 40", imem_addr); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL rd_next_valid got %b want 1", if_valid); end
    checks++; if (if_pc !== 32'h40) begin errors++; $display("FAIL rd_next_pc got %h want 40", if_pc); end
    checks++; if (if_instr !== 32'h2408_1234) begin errors++; $display("FAIL rd_next_instr got %h want 24081234", if_instr); end
    id_ready = 1'b1;
  endtask

  task automatic test_fault();
    do_reset();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL flt_set got %b want 1", fetch_fault); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL flt_valid got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL flt_instr got %h want 0", if_instr); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL flt_addr got %h want 4", imem_addr); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL flt_frozen_valid[%0d] got %b want 0", k, if_valid); end
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL flt_frozen_addr[%0d] got %h want 4", k, imem_addr); end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL flt_ignore_addr got %h want 4", imem_addr); end
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL flt_sticky got %b want 1", fetch_fault); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL flt_ignore_valid got %b want 0", if_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL flt_clear got %b want 0", fetch_fault); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL flt_reset_addr got %h want 0", imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    imem[255] = 32'h0800_0000;
    imem[0]   = 32'h8C09_0000;
    do_reset();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3FC;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (if_pc !== 32'h3FC) begin errors++; $display("FAIL wrap_pc got %h want 3fc", if_pc); end
    checks++; if (if_pc_plus4 !== 32'h400) begin errors++; $display("FAIL wrap_pc4 got %h want 400", if_pc_plus4); end
    checks++; if (if_instr !== 32'h0800_0000) begin errors++; $display("FAIL wrap_instr got %h want 08000000", if_instr); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc got %h want 0", if_pc); end
    checks++; if (if_instr !== 32'h8C09_0000) begin errors++; $display("FAIL wrap_next_instr got %h want 8c090000", if_instr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL arst_instr got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL arst_pc got %h want 0", if_pc); end
    checks++; if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL arst_pc4 got %h want 0", if_pc_plus4); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL arst_addr got %h want 0", imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stream-level model: the decoder must see consecutive words from the last
  // redirect target, and if_valid drops only for the cycle after a redirect.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        exp_valid;
    logic        prev_redirect;
    logic        rdy;
    logic        redir;
    for (int k = 0; k < 256; k++) imem[k] = $urandom;
    do_reset();
    @(negedge clk);
    exp_pc = 32'h0;
    prev_redirect = 1'b0;
    for (int i = 0; i < 600; i++) begin
      exp_valid = !prev_redirect;
      checks++; if (if_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, if_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (if_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", i, if_pc, exp_pc); end
        checks++; if (if_instr !== imem[exp_pc[9:2]]) begin errors++; $display("FAIL rnd_instr[%0d] got %h want %h", i, if_instr, imem[exp_pc[9:2]]); end
        checks++; if (if_pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4[%0d] got %h want %h", i, if_pc_plus4, exp_pc + 32'd4); end
        checks++; if (imem_addr !== seq_next(exp_pc)) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", i, imem_addr, seq_next(exp_pc)); end
      end else begin
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rnd_flush_instr[%0d] got %h want 0", i, if_instr); end
        checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_flush_addr[%0d] got %h want %h", i, imem_addr, exp_pc); end
      end
      rdy = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 9) == 0);
      tgt = 32'($urandom_range(0, 255)) << 2;
      if (exp_valid && rdy) exp_pc = seq_next(exp_pc);
      if (redir) exp_pc = tgt;
      prev_redirect = redir;
      id_ready = rdy;
      redirect_valid = redir;
      redirect_pc = tgt;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    id_ready = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) imem[k] = 32'h0;
    test_reset();
    test_sequence();
    test_backpressure();
    test_redirect_flush();
    test_fault();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
